seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
- Runtime-programmable serial pattern detector; parametrised successor of the fixed 1011 detector.
- Pattern value, length (1..MAX_LEN) and overlap mode are loaded through a config port.
- Sits on the serial bit stream, qualified by in_valid; emits a one-cycle registered match pulse.
- Optional saturating match counter is provided for debug and status.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 16, match counter width; used only with the optional feature.
- LEN_W (localparam), $clog2(MAX_LEN+1), width of length fields.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config load strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when cfg_len is illegal.
- in_valid  in  1  qualifies in_bit.
- in_bit  in  1  serial data bit.
- armed  out  1  high while a legal config is loaded (state RUN).
- seq_seen  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  saturating match count; present only with the optional feature.

Behaviour:
- Reset values: armed=0, seq_seen=0, cfg_err=0, match_cnt=0. Internal: state=UNCFG, hist=0, fill=0, pattern=0, len=0, overlap=0.
- FSM has two states:
  - UNCFG: in_bit is ignored.
  - RUN: detection is active.
- A legal cfg_valid (1<=cfg_len<=MAX_LEN), accepted in any state:
  - latches pattern, len and overlap;
  - clears hist, fill and match_cnt;
  - moves to RUN; armed=1 from the next cycle.
- An illegal cfg_valid (cfg_len=0 or >MAX_LEN):
  - cfg_err=1 for exactly one cycle;
  - state, config, hist, fill and match_cnt are unchanged.
- cfg_valid and in_valid in the same cycle: config wins. The bit is dropped and seq_seen=0 the next cycle.
- In RUN with in_valid=1:
  - hist_n = {hist[MAX_LEN-2:0], in_bit};
  - fill_n = min(fill+1, len);
  - hit = (fill_n==len) && (hist_n[len-1:0] == pattern[len-1:0]); bits at or above len are ignored.
- seq_seen <= hit. Latency is 1 cycle: the pulse appears in the cycle after the edge that samples the completing bit.
- After a hit:
  - overlap=1: fill stays at len, so the next match may share bits.
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
- in_valid=0: hist, fill and state hold; seq_seen=0.
- No match is possible before len valid bits have been received since the last config or reset.
- reset asserted mid-stream overrides everything, including a concurrent cfg_valid; all state returns to reset values.
- len=1: every valid bit equal to pattern[0] hits; back-to-back pulses are legal.
- Holding in_valid=1 continuously with repeated hits gives seq_seen high on consecutive cycles.

Optional Feature:
- Macro: SEQ_DETECT_PROG_MATCH_CNT_EN.
- Defined:
  - match_cnt port exists;
  - increments on each hit and saturates at 2^CNT_W-1 (no wrap);
  - cleared by reset or a legal config load;
  - an illegal config leaves it unchanged;
  - updates in the same cycle seq_seen asserts.
- Undefined: match_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Legacy case, overlap: config pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> seq_seen pulses after the 4th and 7th bits; match_cnt=2.
- Same stream with overlap=0 -> single pulse after the 4th bit; the 7th bit does not hit; match_cnt=1.
- Illegal config: cfg_len=0 while armed with 1011 -> cfg_err=1 for one cycle; armed stays 1; stream 1011 still hits.
- Stalls and early data:
  - bits 1,0 then in_valid=0 for 5 cycles, then 1,1 -> one pulse.
  - Before any config, stream 1011 -> no pulse and armed=0.
- Saturation: MAX_LEN=8, CNT_W=2, len=1, pattern=1, overlap=1; six consecutive valid 1s -> six back-to-back pulses; match_cnt sticks at 3.
- Reset mid-stream: send 1,0,1; assert reset; reconfigure 1011; send 1 -> no pulse; sending 0,1,1 then gives one pulse.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with a registered one-cycle match pulse.
// Optional saturating match counter: define SEQ_DETECT_PROG_MATCH_CNT_EN.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               armed,
    output logic               seq_seen
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    typedef enum logic {UNCFG, RUN} state_t;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    // The oldest history bit can never take part in a compare, so it is not stored.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;

    logic               cfg_legal;
    logic               cfg_load;
    logic               shift;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    always_comb begin
        cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        cfg_load  = cfg_valid && cfg_legal;
        // A config strobe takes precedence, so a coincident data bit is dropped.
        shift     = (state == RUN) && in_valid && !cfg_valid;
        hist_n    = {hist, in_bit};
        fill_n    = (fill < len) ? fill + 1'b1 : len;
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
        hit = shift && (fill_n == len) && (((hist_n ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= UNCFG;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            UNCFG:   if (cfg_load) state_n = RUN;
            RUN:     state_n = RUN;
            default: state_n = UNCFG;
        endcase
    end

    assign armed = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err  <= 1'b0;
            seq_seen <= 1'b0;
            pattern  <= '0;
            len      <= '0;
            overlap  <= 1'b0;
            hist     <= '0;
            fill     <= '0;
        end else begin
            cfg_err  <= cfg_valid && !cfg_legal;
            seq_seen <= hit;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (shift) begin
                hist <= hist_n[MAX_LEN-2:0];
                fill <= (hit && !overlap) ? '0 : fill_n;
            end
        end
    end

`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || cfg_load)
            match_cnt <= '0;
        else if (hit && !(&match_cnt))
            match_cnt <= match_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_valid;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               in_valid;
    logic               in_bit;
    logic               armed;
    logic               seq_seen;
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_bit(in_bit),
        .armed(armed), .seq_seen(seq_seen)
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
        , .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
        chk(tag, 32'(match_cnt), 32'(exp));
`endif
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic cv, input logic [7:0] pat, input logic [3:0] ln,
                       input logic ov, input logic iv, input logic b);
        cfg_valid   = cv;
        cfg_pattern = pat;
        cfg_len     = ln;
        cfg_overlap = ov;
        in_valid    = iv;
        in_bit      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
        cyc(1'b1, pat, ln, ov, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] stream;
        logic [6:0] hits;
        logic [3:0] s4;

        reset = 1'b1;
        idle();
        idle();
        chk("reset_armed", 32'(armed), 0);
        chk("reset_seen", 32'(seq_seen), 0);
        chk("reset_err", 32'(cfg_err), 0);
        chk_cnt("reset_cnt", 0);
        reset = 1'b0;

        // Unconfigured: data is ignored
        s4 = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            bit_in(s4[i]);
            chk("uncfg_seen", 32'(seq_seen), 0);
        end
        chk("uncfg_armed", 32'(armed), 0);

        // Overlapping 1011 on stream 1,0,1,1,0,1,1
        load(8'b1011, 4'd4, 1'b1);
        chk("cfg_armed", 32'(armed), 1);
        chk("cfg_seen", 32'(seq_seen), 0);
        stream = 7'b1011011;
        hits   = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            bit_in(stream[i]);
            chk("ovl_seen", 32'(seq_seen), 32'(hits[i]));
        end
        chk_cnt("ovl_cnt", 2);

        // Non-overlapping on the same stream
        load(8'b1011, 4'd4, 1'b0);
        chk_cnt("nov_cnt_clr", 0);
        hits = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            bit_in(stream[i]);
            chk("nov_seen", 32'(seq_seen), 32'(hits[i]));
        end
        chk_cnt("nov_cnt", 1);

        // Illegal configs leave the loaded 1011 in place
        load(8'b1011, 4'd4, 1'b0);
        load(8'hff, 4'd0, 1'b1);
        chk("ill0_err", 32'(cfg_err), 1);
        chk("ill0_armed", 32'(armed), 1);
        idle();
        chk("ill0_err_drop", 32'(cfg_err), 0);
        load(8'hff, 4'd9, 1'b1);
        chk("ill9_err", 32'(cfg_err), 1);
        hits = 7'b0000001;
        for (int i = 3; i >= 0; i--) begin
            bit_in(s4[i]);
            chk("ill_seen", 32'(seq_seen), 32'(hits[i]));
        end
        chk("ill_err_quiet", 32'(cfg_err), 0);
        chk_cnt("ill_cnt", 1);

        // Stall in the middle of a pattern
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("stall_seen", 32'(seq_seen), 0);
        end
        bit_in(1'b1);
        chk("stall_seen3", 32'(seq_seen), 0);
        bit_in(1'b1);
        chk("stall_hit", 32'(seq_seen), 1);
        idle();
        chk("stall_after", 32'(seq_seen), 0);

        // Config wins over a coincident data bit; the bit is dropped
        cyc(1'b1, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1);
        chk("coinc_seen", 32'(seq_seen), 0);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("coinc_dropped", 32'(seq_seen), 0);

        // Reset mid-stream overrides a concurrent config
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        reset = 1'b1;
        load(8'b1011, 4'd4, 1'b1);
        chk("rst_armed", 32'(armed), 0);
        reset = 1'b0;
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1);
        chk("rst_nohit", 32'(seq_seen), 0);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("rst_pre", 32'(seq_seen), 0);
        bit_in(1'b1);
        chk("rst_hit", 32'(seq_seen), 1);

        // len=1 back-to-back hits and counter saturation
        load(8'b1, 4'd1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            bit_in(1'b1);
            chk("len1_seen", 32'(seq_seen), 1);
            chk_cnt("len1_cnt", (i > 3) ? 3 : i);
        end
        bit_in(1'b0);
        chk("len1_zero", 32'(seq_seen), 0);
        chk_cnt("len1_cnt_hold", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
